// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squashes, memory waits, watchdog.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fwd_en,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [ADDR_W-1:0] exe_dest,
  input  logic              exe_mem_r_en,
  input  logic              exe_wb_en,
  input  logic              exe_br_taken,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              freeze_pc,
  output logic              freeze_if_id,
  output logic              freeze_id_exe,
  output logic              freeze_exe_mem,
  output logic              flush_if_id,
  output logic              flush_id_exe,
  output logic              mem_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_ld_stall,
  output logic [STAT_W-1:0] stat_br_flush,
  output logic [STAT_W-1:0] stat_mem_wait
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ld_use, raw_nofwd, hazard;

  // Register 0 is hardwired, so a match on it is never a dependency.
  function automatic logic src_match(input logic [ADDR_W-1:0] dest,
                                     input logic [ADDR_W-1:0] s1,
                                     input logic [ADDR_W-1:0] s2,
                                     input logic              two);
    return (dest != '0) && ((dest == s1) || (two && (dest == s2)));
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign ld_use    = exe_mem_r_en && src_match(exe_dest, id_src1, id_src2, id_two_src);
  assign raw_nofwd = !fwd_en &&
                     ((exe_wb_en && src_match(exe_dest, id_src1, id_src2, id_two_src)) ||
                      (mem_wb_en && src_match(mem_dest, id_src1, id_src2, id_two_src)));
  assign hazard    = ld_use || raw_nofwd;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    freeze_pc      = 1'b0;
    freeze_if_id   = 1'b0;
    freeze_id_exe  = 1'b0;
    freeze_exe_mem = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_exe   = 1'b0;
    mem_timeout    = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem} = 4'b1111;
          state_nxt = MEM_WAIT;
          cnt_nxt   = CNT_W'(1);
        end else if (exe_br_taken) begin
          flush_if_id  = 1'b1;
          flush_id_exe = 1'b1;
        end else if (hazard) begin
          freeze_pc    = 1'b1;
          freeze_if_id = 1'b1;
          flush_id_exe = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Whole pipe held; any pending branch/hazard is re-evaluated once back in RUN.
        {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem} = 4'b1111;
        if (mem_ready) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_CNT) begin
          state_nxt = ERR;
        end else begin
          cnt_nxt = cnt_sat_inc(cnt);
        end
      end
      ERR: begin
        {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem} = 4'b1111;
        mem_timeout = 1'b1;
      end
      default: begin
        {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem} = 4'b1111;
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
    if (rst) begin
      {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem} = 4'b0000;
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
      mem_timeout  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  // A bubble is the only case that flushes ID/EXE without flushing IF/ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ld_stall <= '0;
      stat_br_flush <= '0;
      stat_mem_wait <= '0;
    end else begin
      if (flush_id_exe && !flush_if_id) stat_ld_stall <= stat_sat_inc(stat_ld_stall);
      if (flush_if_id)                  stat_br_flush <= stat_sat_inc(stat_br_flush);
      if (state == MEM_WAIT)            stat_mem_wait <= stat_sat_inc(stat_mem_wait);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: literal expectations per step plus a cycle-by-cycle reference model.
module tb_pipe_hazard_ctrl;
  localparam int ADDR_W = 5;
  localparam int TO     = 4;

  localparam logic [6:0] IDLE   = 7'b0000000;
  localparam logic [6:0] ALLFZ  = 7'b1111000;
  localparam logic [6:0] FLUSH2 = 7'b0000110;
  localparam logic [6:0] BUBBLE = 7'b1100010;
  localparam logic [6:0] ERRO   = 7'b1111001;

  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_ERR  = 2;

  logic clk = 1'b0;
  logic rst, fwd_en, id_two_src, exe_mem_r_en, exe_wb_en, exe_br_taken;
  logic mem_wb_en, mem_req, mem_ready;
  logic [ADDR_W-1:0] id_src1, id_src2, exe_dest, mem_dest;
  logic freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem;
  logic flush_if_id, flush_id_exe, mem_timeout;
`ifdef HAZARD_STATS_EN
  logic [15:0] stat_ld_stall, stat_br_flush, stat_mem_wait;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit model_on = 1'b0;
  int m_mode = M_RUN;
  int m_stalled = 0;
  int cyc_no = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.ADDR_W(ADDR_W), .MEM_TIMEOUT(TO), .CNT_W(8), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en), .exe_wb_en(exe_wb_en),
    .exe_br_taken(exe_br_taken), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .freeze_id_exe(freeze_id_exe),
    .freeze_exe_mem(freeze_exe_mem), .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_STATS_EN
    , .stat_ld_stall(stat_ld_stall), .stat_br_flush(stat_br_flush), .stat_mem_wait(stat_mem_wait)
`endif
  );

  function automatic logic [6:0] outs();
    return {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
            flush_if_id, flush_id_exe, mem_timeout};
  endfunction

  // Does a write to dest collide with a source the ID instruction actually reads?
  function automatic bit reads_reg(input logic [ADDR_W-1:0] dest);
    if (dest == 0) return 0;
    return (dest == id_src1) || (id_two_src && dest == id_src2);
  endfunction

  // Reference model: mode plus number of consecutive unanswered stall cycles.
  always @(negedge clk) begin
    logic [6:0] e;
    bit hz;
    if (model_on) begin
      cyc_no++;
      e = IDLE;
      hz = (exe_mem_r_en && reads_reg(exe_dest)) ||
           (!fwd_en && exe_wb_en && reads_reg(exe_dest)) ||
           (!fwd_en && mem_wb_en && reads_reg(mem_dest));
      if (rst) begin
        e = FLUSH2;
        m_mode = M_RUN;
        m_stalled = 0;
      end else if (m_mode == M_ERR) begin
        e = ERRO;
      end else if (m_mode == M_WAIT) begin
        e = ALLFZ;
        if (mem_ready) begin
          m_mode = M_RUN;
          m_stalled = 0;
        end else begin
          m_stalled++;
          if (m_stalled > TO) m_mode = M_ERR;
        end
      end else begin
        if (mem_req && !mem_ready) begin
          e = ALLFZ;
          m_mode = M_WAIT;
          m_stalled = 1;
        end else if (exe_br_taken) e = FLUSH2;
        else if (hz) e = BUBBLE;
      end
      vectors++;
      if (outs() !== e) begin
        miscompares++;
        $display("FAIL model cyc=%0d outs got %b want %b (pc,ifid,idexe,exemem,flifid,flidexe,to)",
                 cyc_no, outs(), e);
      end
    end
  end

  task automatic idle_in();
    rst = 0; fwd_en = 1; id_src1 = 0; id_src2 = 0; id_two_src = 0;
    exe_dest = 0; exe_mem_r_en = 0; exe_wb_en = 0; exe_br_taken = 0;
    mem_dest = 0; mem_wb_en = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Check the current cycle's outputs, then advance to just after the next rising edge.
  task automatic cyc(input string name, input logic [6:0] exp);
    @(negedge clk);
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL %s got %b want %b", name, outs(), exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_in();
    rst = 1;
    model_on = 1'b1;
    cyc("reset", FLUSH2);
    rst = 0;
    cyc("idle", IDLE);

    exe_mem_r_en = 1; exe_dest = 5; id_src1 = 5;
    cyc("ld_use", BUBBLE);
    exe_mem_r_en = 0; exe_dest = 0;
    cyc("ld_use_once", IDLE);
    exe_mem_r_en = 1; exe_dest = 0; id_src1 = 0;
    cyc("ld_use_r0", IDLE);
    exe_dest = 5; id_src1 = 5; exe_br_taken = 1;
    cyc("br_over_hz", FLUSH2);

    idle_in(); mem_req = 1;
    cyc("mw1", ALLFZ);
    cyc("mw2", ALLFZ);
    cyc("mw3", ALLFZ);
    mem_ready = 1;
    cyc("mw4_ready", ALLFZ);
    idle_in();
    cyc("mw_done", IDLE);

    mem_req = 1;
    for (int i = 0; i < 4; i++) cyc("mw_edge", ALLFZ);
    mem_ready = 1;
    cyc("mw_edge_ready", ALLFZ);
    idle_in();
    cyc("mw_edge_done", IDLE);

    exe_br_taken = 1; mem_req = 1;
    cyc("br_held_req", ALLFZ);
    mem_ready = 1;
    cyc("br_held_ready", ALLFZ);
    mem_req = 0; mem_ready = 0;
    cyc("br_after_wait", FLUSH2);

    idle_in(); fwd_en = 0; mem_wb_en = 1; mem_dest = 7; id_two_src = 1; id_src2 = 7;
    cyc("nofwd_src2", BUBBLE);
    id_two_src = 0;
    cyc("nofwd_one_src", IDLE);
    id_two_src = 1; fwd_en = 1;
    cyc("fwd_covers", IDLE);
    idle_in(); fwd_en = 0; exe_wb_en = 1; exe_dest = 3; id_src1 = 3;
    cyc("nofwd_exe", BUBBLE);

    idle_in(); mem_req = 1;
    cyc("rmw1", ALLFZ);
    cyc("rmw2", ALLFZ);
    rst = 1;
    cyc("rst_mid_wait", FLUSH2);
    rst = 0; mem_req = 0;
    cyc("after_rst", IDLE);

    mem_req = 1;
    for (int i = 0; i < 5; i++) cyc("wd_stall", ALLFZ);
    cyc("wd_err", ERRO);
    mem_req = 0; mem_ready = 1;
    cyc("wd_err_held", ERRO);
    rst = 1;
    cyc("wd_rst", FLUSH2);
    idle_in();
    cyc("wd_cleared", IDLE);

    model_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
